// File: rtl/seg7_display_sched.sv
// seg7_display_sched
// Chooses which of four 32-bit sources feeds the 8-digit seven-segment
// driver. It supports a fixed source, timed round-robin rotation, freeze,
// and a CPU override that shows a written value for HOLD_CYCLES clocks.
// disp_data/disp_cs connect directly to the seg7x16 driver's i_data/cs.
// disp_cs is a one-cycle load pulse that fires only when the displayed
// word changes. An override write always fires it.
module seg7_display_sched #(
   parameter int ROT_CYCLES  = 50000000,
   parameter int HOLD_CYCLES = 100000000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [127:0] src_data,
   input  logic [3:0]   src_en,
   input  logic         ctrl_we,
   input  logic [3:0]   ctrl_wdata,
   input  logic         ovr_we,
   input  logic [31:0]  ovr_data,
   output logic [31:0]  disp_data,
   output logic         disp_cs,
   output logic [1:0]   cur_src,
   output logic         ovr_active
);

   localparam int ROT_W  = (ROT_CYCLES  > 1) ? $clog2(ROT_CYCLES)  : 1;
   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   // SHOW: sources feed the display; OVR: the override word is held
   typedef enum logic {
      SHOW = 1'b0,
      OVR  = 1'b1
   } state_t;

   state_t            state, state_nxt;
   logic [3:0]        ctrl, ctrl_nxt;        // [0]=auto_rotate [2:1]=fixed_sel [3]=freeze
   logic [1:0]        cur_nxt;
   logic [ROT_W-1:0]  rot_cnt, rot_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic [31:0]       data_nxt;
   logic              cs_nxt;

   logic [1:0]        sel;
   logic [31:0]       sel_word;
   logic [1:0]        next_src;
   logic [1:0]        cand;
   logic              found;

   assign ovr_active = (state == OVR);

   // Effective source and the next enabled source after cur_src, searched in rotation order
   always_comb begin
      sel      = ctrl[0] ? cur_src : ctrl[2:1];
      sel_word = src_data[{sel, 5'd0} +: 32];
      next_src = cur_src;
      found    = 1'b0;
      cand     = cur_src;
      for (int k = 1; k < 4; k++) begin
         cand = cur_src + 2'(k);
         if (!found && src_en[cand]) begin
            next_src = cand;
            found    = 1'b1;
         end
      end
   end

   // Next-state, display load and rotation/hold counter logic
   always_comb begin
      state_nxt = state;
      ctrl_nxt  = ctrl;
      cur_nxt   = cur_src;
      rot_nxt   = rot_cnt;
      hold_nxt  = hold_cnt;
      data_nxt  = disp_data;
      cs_nxt    = 1'b0;

      case (state)
         SHOW: begin
            if (!ctrl[3] && src_en[sel]) begin
               data_nxt = sel_word;
               cs_nxt   = (sel_word != disp_data);
            end
         end
         OVR: begin
            if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
               state_nxt = SHOW;
               hold_nxt  = '0;
            end else begin
               hold_nxt = hold_cnt + HOLD_W'(1);
            end
         end
         default: state_nxt = SHOW;
      endcase

      // An override write wins over any source load and ignores freeze
      if (ovr_we) begin
         state_nxt = OVR;
         data_nxt  = ovr_data;
         cs_nxt    = 1'b1;
         hold_nxt  = '0;
      end

      // A control write wins over a rotation expiry in the same cycle
      if (ctrl_we) begin
         ctrl_nxt = ctrl_wdata;
         rot_nxt  = '0;
         cur_nxt  = ctrl_wdata[2:1];
      end else if (!ctrl[0]) begin
         rot_nxt = '0;
      end else if (state == SHOW) begin
         if (rot_cnt == ROT_W'(ROT_CYCLES - 1)) begin
            rot_nxt = '0;
            cur_nxt = next_src;
         end else begin
            rot_nxt = rot_cnt + ROT_W'(1);
         end
      end
   end

   // State and datapath registers, asynchronously cleared
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= SHOW;
         ctrl      <= '0;
         cur_src   <= '0;
         rot_cnt   <= '0;
         hold_cnt  <= '0;
         disp_data <= '0;
         disp_cs   <= 1'b0;
      end else begin
         state     <= state_nxt;
         ctrl      <= ctrl_nxt;
         cur_src   <= cur_nxt;
         rot_cnt   <= rot_nxt;
         hold_cnt  <= hold_nxt;
         disp_data <= data_nxt;
         disp_cs   <= cs_nxt;
      end
   end

endmodule

// File: tb/tb_seg7_display_sched.sv
// Bench for seg7_display_sched. A behavioural model tracks elapsed slot
// cycles and remaining override cycles. It is compared with the DUT on
// every cycle. Every load pulse is also checked against a queue of the
// words the model expects to load.
module tb_seg7_display_sched;

   localparam int ROT  = 4;
   localparam int HOLD = 6;

   logic         clk = 1'b0;
   logic         reset;
   logic [127:0] src_data;
   logic [3:0]   src_en;
   logic         ctrl_we;
   logic [3:0]   ctrl_wdata;
   logic         ovr_we;
   logic [31:0]  ovr_data;
   logic [31:0]  disp_data;
   logic         disp_cs;
   logic [1:0]   cur_src;
   logic         ovr_active;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] exp_q[$];

   // model state
   logic [3:0]  m_ctrl;
   int          m_cur;
   int          m_slot;      // cycles spent in the current rotation slot
   int          m_ovr_left;  // override cycles still to show (0 = not overriding)
   logic [31:0] m_data;
   logic        m_cs;

   always #5 clk = ~clk;

   seg7_display_sched #(
      .ROT_CYCLES (ROT),
      .HOLD_CYCLES(HOLD)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .src_data  (src_data),
      .src_en    (src_en),
      .ctrl_we   (ctrl_we),
      .ctrl_wdata(ctrl_wdata),
      .ovr_we    (ovr_we),
      .ovr_data  (ovr_data),
      .disp_data (disp_data),
      .disp_cs   (disp_cs),
      .cur_src   (cur_src),
      .ovr_active(ovr_active)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ctrl     = 4'd0;
      m_cur      = 0;
      m_slot     = 0;
      m_ovr_left = 0;
      m_data     = 32'd0;
      m_cs       = 1'b0;
      exp_q.delete();
   endtask

   // One clock of the reference model. It uses the inputs seen at this edge.
   task automatic model_step();
      int   sel;
      logic auto_r;
      logic in_ovr;
      logic [31:0] w;
      bit   done;
      auto_r = m_ctrl[0];
      in_ovr = (m_ovr_left > 0);
      sel    = auto_r ? m_cur : int'(m_ctrl[2:1]);
      w      = src_data[sel*32 +: 32];

      if (ovr_we) begin
         m_data     = ovr_data;
         m_cs       = 1'b1;
         m_ovr_left = HOLD;
      end else if (in_ovr) begin
         m_cs = 1'b0;
         m_ovr_left--;
      end else if (!m_ctrl[3] && src_en[sel]) begin
         m_cs   = (w != m_data);
         m_data = w;
      end else begin
         m_cs = 1'b0;
      end
      if (m_cs) exp_q.push_back(m_data);

      if (ctrl_we) begin
         m_ctrl = ctrl_wdata;
         m_slot = 0;
         m_cur  = int'(ctrl_wdata[2:1]);
      end else if (!auto_r) begin
         m_slot = 0;
      end else if (!in_ovr) begin
         m_slot++;
         if (m_slot == ROT) begin
            m_slot = 0;
            done   = 0;
            for (int k = 1; k < 4; k++) begin
               if (!done && src_en[(m_cur + k) % 4]) begin
                  m_cur = (m_cur + k) % 4;
                  done  = 1;
               end
            end
         end
      end
   endtask

   task automatic compare();
      logic [31:0] head;
      check("disp_data", disp_data, m_data);
      check("disp_cs", {31'd0, disp_cs}, {31'd0, m_cs});
      check("cur_src", {30'd0, cur_src}, 32'(m_cur));
      check("ovr_active", {31'd0, ovr_active}, {31'd0, (m_ovr_left > 0)});
      if (disp_cs) begin
         check("load_pending", 32'(exp_q.size()), 32'd1);
         if (exp_q.size() > 0) begin
            head = exp_q.pop_front();
            check("load_word", disp_data, head);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic pulse_ctrl(input logic [3:0] w);
      ctrl_we    = 1'b1;
      ctrl_wdata = w;
      step();
      ctrl_we    = 1'b0;
   endtask

   task automatic pulse_ovr(input logic [31:0] d);
      ovr_we   = 1'b1;
      ovr_data = d;
      step();
      ovr_we   = 1'b0;
   endtask

   initial begin
      int idx;
      reset      = 1'b1;
      src_data   = '0;
      src_en     = 4'hF;
      ctrl_we    = 1'b0;
      ctrl_wdata = 4'd0;
      ovr_we     = 1'b0;
      ovr_data   = 32'd0;
      model_reset();
      repeat (2) @(negedge clk);

      // reset state
      check("rst_disp_data", disp_data, 32'd0);
      check("rst_disp_cs", {31'd0, disp_cs}, 32'd0);
      check("rst_cur_src", {30'd0, cur_src}, 32'd0);
      check("rst_ovr_active", {31'd0, ovr_active}, 32'd0);

      // fixed source 0: one load, then quiet
      src_data[31:0] = 32'h12345678;
      reset = 1'b0;
      step();
      check("t1_data", disp_data, 32'h12345678);
      check("t1_cs", {31'd0, disp_cs}, 32'd1);
      repeat (5) step();

      // rotation over sources 0,1,3
      src_data = {32'h3, 32'h2, 32'h1, 32'h0};
      src_en   = 4'b1011;
      pulse_ctrl(4'b0001);
      repeat (22) step();

      // override during rotation
      repeat (2) step();
      pulse_ovr(32'hDEADBEEF);
      check("t3_data", disp_data, 32'hDEADBEEF);
      check("t3_active", {31'd0, ovr_active}, 32'd1);
      repeat (12) step();

      // second override write in the middle of the hold
      pulse_ovr(32'hDEADBEEF);
      repeat (4) step();
      pulse_ovr(32'hCAFEF00D);
      check("t4_data", disp_data, 32'hCAFEF00D);
      check("t4_cs", {31'd0, disp_cs}, 32'd1);
      repeat (10) step();

      // freeze on fixed source 2, then an override still gets through
      src_en = 4'hF;
      pulse_ctrl(4'b1100);
      step();
      src_data[95:64] = 32'hA5A5A5A5;
      repeat (3) step();
      pulse_ovr(32'h0BADF00D);
      check("t5_data", disp_data, 32'h0BADF00D);
      repeat (8) step();

      // asynchronous reset in the middle of an override
      pulse_ctrl(4'b0001);
      pulse_ovr(32'h11112222);
      repeat (3) step();
      #2 reset = 1'b1;
      #1;
      check("t6_data", disp_data, 32'd0);
      check("t6_active", {31'd0, ovr_active}, 32'd0);
      check("t6_cur_src", {30'd0, cur_src}, 32'd0);
      check("t6_cs", {31'd0, disp_cs}, 32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (6) step();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         ctrl_we    = ($urandom_range(0, 39) == 0);
         ctrl_wdata = 4'($urandom_range(0, 15));
         ovr_we     = ($urandom_range(0, 59) == 0);
         ovr_data   = $urandom;
         if ($urandom_range(0, 3) == 0) begin
            idx = $urandom_range(0, 3);
            src_data[idx*32 +: 32] = $urandom_range(0, 3);
         end
         if ($urandom_range(0, 49) == 0) src_en = 4'($urandom_range(0, 15));
         step();
      end
      ctrl_we = 1'b0;
      ovr_we  = 1'b0;
      repeat (3) step();
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
